// File: rtl/serial_bus_initiator.sv
// Master-side serial bus engine: serialises one read/write request onto control/wD/valid
// and deserialises the slave's rD stream back into a parallel response.
//
// state    | meaning
// IDLE     | accepting a request (reqReady = 1)
// WAIT_RDY | waiting for the slave to be idle (ready = 1), timeout armed
// CTRL     | start bit, rw, slave ID, address on control, MSB-first
// WDATA    | write data on wD with valid = 1, MSB-first
// WAIT_RD  | waiting for the slave's ready 0->1 edge, timeout armed
// RDATA    | shifting rD in, MSB-first
// DONE     | one-cycle response pulse
module serial_bus_initiator #(
  parameter int SLAVES     = 3,
  parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [S_ID_WIDTH-1:0] reqSlave,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqWData,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspRData,
  output logic                  rspError,
  output logic                  control,
  output logic                  wD,
  output logic                  valid,
  input  logic                  rD,
  input  logic                  ready
);

  localparam int CTRL_LEN = 2 + S_ID_WIDTH + ADDR_WIDTH;
  localparam int MAX_LEN  = (CTRL_LEN > DATA_WIDTH) ? CTRL_LEN : DATA_WIDTH;
  localparam int BIT_W    = $clog2(MAX_LEN);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, CTRL, WDATA, WAIT_RD, RDATA, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CTRL_LEN-1:0]   ctrl_sh_q;
  logic [DATA_WIDTH-1:0] wdata_sh_q, rdata_sh_q, rsp_rdata_q;
  logic                  write_q, err_q, err_d, ready_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_inc;
  logic                  accept, ready_rise, tmo_hit, ctrl_last, data_last;

  assign accept     = reqValid && (state_q == IDLE);
  assign ready_rise = ready && !ready_q;
  // Saturating increment; the compare fires on the cycle the count reaches TIMEOUT.
  assign tmo_inc    = (tmo_cnt_q == TMO_W'(TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
  assign tmo_hit    = (tmo_inc == TMO_W'(TIMEOUT));
  assign ctrl_last  = (bit_cnt_q == BIT_W'(CTRL_LEN - 1));
  assign data_last  = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
  assign rspRData   = rsp_rdata_q;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    reqReady = 1'b0;
    control  = 1'b0;
    wD       = 1'b0;
    valid    = 1'b0;
    rspValid = 1'b0;
    rspError = 1'b0;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          state_d = WAIT_RDY;
          err_d   = 1'b0;
        end
      end
      WAIT_RDY: begin
        if (ready) begin
          state_d = CTRL;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      CTRL: begin
        control = ctrl_sh_q[CTRL_LEN-1];
        if (ctrl_last) state_d = write_q ? WDATA : WAIT_RD;
      end
      WDATA: begin
        valid = 1'b1;
        wD    = wdata_sh_q[DATA_WIDTH-1];
        if (data_last) state_d = DONE;
      end
      WAIT_RD: begin
        if (ready_rise) begin
          state_d = RDATA;
        end else if (tmo_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      RDATA: begin
        if (data_last) state_d = DONE;
      end
      DONE: begin
        rspValid = 1'b1;
        rspError = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      ctrl_sh_q   <= '0;
      wdata_sh_q  <= '0;
      rdata_sh_q  <= '0;
      rsp_rdata_q <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ready_q <= ready;

      if (accept) begin
        ctrl_sh_q  <= {1'b1, reqWrite, reqSlave, reqAddr};
        wdata_sh_q <= reqWData;
        write_q    <= reqWrite;
      end else begin
        if (state_q == CTRL)  ctrl_sh_q  <= ctrl_sh_q << 1;
        if (state_q == WDATA) wdata_sh_q <= wdata_sh_q << 1;
      end

      // Only a completed RDATA phase reaches this, so timeouts leave rspRData untouched.
      if (state_q == RDATA) begin
        rdata_sh_q <= {rdata_sh_q[DATA_WIDTH-2:0], rD};
        if (data_last) rsp_rdata_q <= {rdata_sh_q[DATA_WIDTH-2:0], rD};
      end

      if (state_d != state_q) begin
        bit_cnt_q <= '0;
      end else if (state_q == CTRL || state_q == WDATA || state_q == RDATA) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end

      if (state_d != state_q) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == WAIT_RDY && !ready) || state_q == WAIT_RD) begin
        tmo_cnt_q <= tmo_inc;
      end
    end
  end

endmodule

// File: tb/tb_serial_bus_initiator.sv
// Self-checking bench for serial_bus_initiator: table of transactions plus hand-written
// back-to-back and mid-transaction reset sequences; responses checked via a scoreboard queue.
module tb_serial_bus_initiator;

  localparam int SID_W    = 2;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 8;
  localparam int CTRL_LEN = 16;
  localparam int TMO      = 1023;

  logic              clk = 1'b0;
  logic              rstN;
  logic              reqValid, reqReady, reqWrite;
  logic [SID_W-1:0]  reqSlave;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWData;
  logic              rspValid, rspError;
  logic [DATA_W-1:0] rspRData;
  logic              control, wD, valid, rD, ready;

  always #5 clk = ~clk;

  serial_bus_initiator #(
    .SLAVES(3), .S_ID_WIDTH(SID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSlave(reqSlave), .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspRData(rspRData), .rspError(rspError),
    .control(control), .wD(wD), .valid(valid), .rD(rD), .ready(ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        err;
    logic [7:0]  rdata;
    logic        has_ctrl;
    logic [15:0] ctrl;
    int          wd_n;
    logic [7:0]  wd;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: captures the serial lines between responses and scores each rspValid pulse.
  logic [15:0] ctrl_word;
  int          ctrl_cnt;
  logic [7:0]  wd_word;
  int          wd_cnt;
  logic        overlap;
  exp_t        e_m;

  initial begin
    ctrl_word = '0; ctrl_cnt = 0; wd_word = '0; wd_cnt = 0; overlap = 1'b0;
  end

  always @(negedge clk) begin
    if (!rstN) begin
      ctrl_word = '0; ctrl_cnt = 0; wd_word = '0; wd_cnt = 0; overlap = 1'b0;
    end else begin
      if (control || (ctrl_cnt != 0 && ctrl_cnt < CTRL_LEN)) begin
        ctrl_word = {ctrl_word[14:0], control};
        ctrl_cnt++;
      end
      if (valid) begin
        wd_word = {wd_word[6:0], wD};
        wd_cnt++;
      end
      if (control && valid) overlap = 1'b1;
      if (rspValid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", rspValid, 0);
        end else begin
          e_m = sb_q.pop_front();
          chk("rsp_error", rspError, e_m.err);
          chk("rsp_rdata", rspRData, e_m.rdata);
          chk("ctrl_bit_count", ctrl_cnt, e_m.has_ctrl ? CTRL_LEN : 0);
          if (e_m.has_ctrl) chk("ctrl_frame", ctrl_word, e_m.ctrl);
          chk("wd_bit_count", wd_cnt, e_m.wd_n);
          if (e_m.wd_n != 0) chk("wd_word", wd_word, e_m.wd);
          chk("ctrl_valid_overlap", overlap, 0);
        end
        ctrl_word = '0; ctrl_cnt = 0; wd_word = '0; wd_cnt = 0; overlap = 1'b0;
      end
    end
  end

  typedef enum int {RDY_HIGH, RDY_LATE, RDY_LOW, RD_NORMAL, RD_NODROP} mode_e;

  typedef struct {
    logic        wr;
    logic [1:0]  slave;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  stream;
    mode_e       mode;
    logic        exp_err;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_ctrl;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic set_vec(input int i, input logic wr, input logic [1:0] slave,
                         input logic [11:0] addr, input logic [7:0] wdata,
                         input logic [7:0] stream, input mode_e mode, input logic exp_err,
                         input logic [7:0] exp_rdata, input logic [15:0] exp_ctrl,
                         input int exp_lat);
    vecs[i].wr = wr;           vecs[i].slave = slave;        vecs[i].addr = addr;
    vecs[i].wdata = wdata;     vecs[i].stream = stream;      vecs[i].mode = mode;
    vecs[i].exp_err = exp_err; vecs[i].exp_rdata = exp_rdata;
    vecs[i].exp_ctrl = exp_ctrl; vecs[i].exp_lat = exp_lat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave model, indexed by cycles since the accept edge (j = 1 is the first busy cycle).
  function automatic logic ready_at(input mode_e m, input int j);
    case (m)
      RDY_LATE:  return (j >= 6);
      RDY_LOW:   return 1'b0;
      RD_NORMAL: return (j < 20 || j >= 40);
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic rd_at(input vec_t v, input int j);
    logic [7:0] s;
    s = v.stream;
    if (v.mode == RD_NORMAL && j >= 41 && j <= 48) return s[7-(j-41)];
    return 1'b0;
  endfunction

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   j, guard;
    logic acc;
    reqWrite = v.wr; reqSlave = v.slave; reqAddr = v.addr; reqWData = v.wdata;
    ready = ready_at(v.mode, 0); rD = 1'b0; reqValid = 1'b1;
    e.err = v.exp_err; e.rdata = v.exp_rdata; e.has_ctrl = (v.mode != RDY_LOW);
    e.ctrl = v.exp_ctrl; e.wd_n = (v.wr && !v.exp_err) ? DATA_W : 0; e.wd = v.wdata;
    sb_q.push_back(e);
    acc = 1'b0; guard = 0;
    while (!acc && guard < 20) begin
      acc = reqReady;
      step();
      guard++;
    end
    if (!acc) begin
      chk("accept_wait", reqReady, 1);
      reqValid = 1'b0;
      return;
    end
    reqValid = 1'b0;
    j = 1;
    while (!rspValid && j < 1200) begin
      ready = ready_at(v.mode, j);
      rD = rd_at(v, j);
      step();
      j++;
    end
    chk("rsp_latency", j, v.exp_lat);
    ready = 1'b1; rD = 1'b0;
    step();
    chk("idle_after_done", reqReady, 1);
  endtask

  task automatic run_b2b();
    exp_t ea, eb;
    int   c, d1, a2, d2, guard;
    logic acc;
    reqWrite = 1'b1; reqSlave = 2'd1; reqAddr = 12'h03C; reqWData = 8'h96;
    ready = 1'b1; rD = 1'b0; reqValid = 1'b1;
    ea.err = 1'b0; ea.rdata = 8'hC3; ea.has_ctrl = 1'b1; ea.ctrl = 16'hD03C; ea.wd_n = 8; ea.wd = 8'h96;
    eb.err = 1'b0; eb.rdata = 8'hC3; eb.has_ctrl = 1'b1; eb.ctrl = 16'hEF00; eb.wd_n = 8; eb.wd = 8'h3A;
    sb_q.push_back(ea);
    sb_q.push_back(eb);
    acc = 1'b0; guard = 0;
    while (!acc && guard < 20) begin
      acc = reqReady;
      step();
      guard++;
    end
    // Requester keeps reqValid high and already presents the second request while busy.
    reqSlave = 2'd2; reqAddr = 12'hF00; reqWData = 8'h3A;
    d1 = -1; a2 = -1; d2 = -1; c = 1;
    while (d2 < 0 && c < 200) begin
      if (rspValid) begin
        if (d1 < 0) d1 = c;
        else if (a2 >= 0) d2 = c;
      end
      if (d1 >= 0 && a2 < 0 && reqReady) a2 = c;
      step();
      c++;
    end
    reqValid = 1'b0;
    chk("b2b_accept_gap", a2 - d1, 1);
    chk("b2b_second_latency", d2 - a2, 26);
    step();
    chk("b2b_idle", reqReady, 1);
  endtask

  task automatic run_reset_mid_wdata();
    int   j, guard;
    logic acc, saw;
    reqWrite = 1'b1; reqSlave = 2'd3; reqAddr = 12'h555; reqWData = 8'hFF;
    ready = 1'b1; rD = 1'b0; reqValid = 1'b1;
    acc = 1'b0; guard = 0;
    while (!acc && guard < 20) begin
      acc = reqReady;
      step();
      guard++;
    end
    reqValid = 1'b0;
    for (j = 1; j < 22; j++) step();
    chk("pre_reset_valid", valid, 1);
    chk("pre_reset_wd", wD, 1);
    #2 rstN = 1'b0;
    #1;
    chk("reset_async_valid", valid, 0);
    chk("reset_async_wd", wD, 0);
    chk("reset_async_control", control, 0);
    chk("reset_no_rsp", rspValid, 0);
    step();
    step();
    rstN = 1'b1;
    chk("reset_release_ready", reqReady, 1);
    chk("reset_rdata_cleared", rspRData, 0);
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      saw = saw | rspValid | control | valid;
      step();
    end
    chk("reset_stays_quiet", saw, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit of 2000000", $time);
    $fatal(1);
  end

  initial begin
    vec_t vpost;
    rstN = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSlave = '0; reqAddr = '0;
    reqWData = '0; rD = 1'b0; ready = 1'b1;
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_reqReady", reqReady, 1);
    chk("reset_control", control, 0);
    chk("reset_wD", wD, 0);
    chk("reset_valid", valid, 0);
    chk("reset_rspValid", rspValid, 0);
    chk("reset_rspError", rspError, 0);
    chk("reset_rspRData", rspRData, 0);
    rstN = 1'b1;
    step();

    //       i  wr    slave  addr     wdata  stream mode       err   rdata  ctrl      lat
    set_vec(0, 1'b1, 2'd2, 12'h0A5, 8'hC3, 8'h00, RDY_HIGH,  1'b0, 8'h00, 16'hE0A5, 26);
    set_vec(1, 1'b0, 2'd1, 12'h001, 8'h00, 8'h5A, RD_NORMAL, 1'b0, 8'h5A, 16'h9001, 49);
    set_vec(2, 1'b1, 2'd3, 12'h123, 8'h55, 8'h00, RDY_LOW,   1'b1, 8'h5A, 16'h0000, 1024);
    set_vec(3, 1'b0, 2'd2, 12'hFFF, 8'h00, 8'h00, RD_NODROP, 1'b1, 8'h5A, 16'hAFFF, 1041);
    set_vec(4, 1'b0, 2'd0, 12'h800, 8'h00, 8'hC3, RD_NORMAL, 1'b0, 8'hC3, 16'h8800, 49);
    set_vec(5, 1'b1, 2'd1, 12'h7FF, 8'h81, 8'h00, RDY_HIGH,  1'b0, 8'hC3, 16'hD7FF, 26);
    set_vec(6, 1'b1, 2'd2, 12'h000, 8'hFF, 8'h00, RDY_LATE,  1'b0, 8'hC3, 16'hE000, 31);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    run_b2b();
    run_reset_mid_wdata();

    vpost.wr = 1'b1; vpost.slave = 2'd2; vpost.addr = 12'h0A5; vpost.wdata = 8'h5A;
    vpost.stream = 8'h00; vpost.mode = RDY_HIGH; vpost.exp_err = 1'b0;
    vpost.exp_rdata = 8'h00; vpost.exp_ctrl = 16'hE0A5; vpost.exp_lat = 26;
    run_vec(vpost);

    repeat (3) step();
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
